// File: rtl/hazard_ctrl.sv
// Hazard controller for the decode/execute pipe: load-use/RAW stalls, branch flushes,
// memory-busy freeze with watchdog, operand forwarding. Optional macro: HAZARD_FWD_EN.
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] i_src1_D,
  input  logic [REG_W-1:0] i_src2_D,
  input  logic             i_use_src1_D,
  input  logic             i_use_src2_D,
  input  logic [REG_W-1:0] i_src1_E,
  input  logic [REG_W-1:0] i_src2_E,
  input  logic [REG_W-1:0] i_Write_Reg_E,
  input  logic             i_REGWrite_E,
  input  logic             i_MEMRead_E,
  input  logic [REG_W-1:0] i_Write_Reg_M,
  input  logic             i_REGWrite_M,
  input  logic [REG_W-1:0] i_Write_Reg_W,
  input  logic             i_REGWrite_W,
  input  logic             i_Branch_E,
  input  logic             i_Taken_E,
  input  logic             i_mem_busy,
  output logic             o_stall_F,
  output logic             o_stall_D,
  output logic             o_stall_E,
  output logic             o_flush_D,
  output logic             o_flush_E,
  output logic [1:0]       o_fwd1_E,
  output logic [1:0]       o_fwd2_E,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_RUN         = 2'd0,
    S_MEM_WAIT    = 2'd1,
    S_ERR_RECOVER = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       busy_cnt_q, busy_cnt_d;
  logic [8:0]       busy_inc;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       hit_e, data_hz, taken;
  logic [1:0] fwd1, fwd2;

  assign hit_e = (i_Write_Reg_E != '0) &&
                 ((i_use_src1_D && (i_src1_D == i_Write_Reg_E)) ||
                  (i_use_src2_D && (i_src2_D == i_Write_Reg_E)));
  assign taken    = i_Branch_E & i_Taken_E;
  assign busy_inc = {1'b0, busy_cnt_q} + 9'd1;

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] wr_m, input logic we_m,
                                         input logic [REG_W-1:0] wr_w, input logic we_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (we_m && (wr_m == src))      sel = 2'b01;
      else if (we_w && (wr_w == src)) sel = 2'b10;
    end
    return sel;
  endfunction

  assign data_hz = i_MEMRead_E & i_REGWrite_E & hit_e;
  assign fwd1    = fwd_sel(i_src1_E, i_Write_Reg_M, i_REGWrite_M, i_Write_Reg_W, i_REGWrite_W);
  assign fwd2    = fwd_sel(i_src2_E, i_Write_Reg_M, i_REGWrite_M, i_Write_Reg_W, i_REGWrite_W);
`else
  logic hit_m;
  logic unused_fwd;

  assign hit_m = (i_Write_Reg_M != '0) &&
                 ((i_use_src1_D && (i_src1_D == i_Write_Reg_M)) ||
                  (i_use_src2_D && (i_src2_D == i_Write_Reg_M)));
  // Without bypass paths every E/M writer must drain; W is covered by write-first regfile.
  assign data_hz    = (i_REGWrite_E & hit_e) | (i_REGWrite_M & hit_m);
  assign fwd1       = 2'b00;
  assign fwd2       = 2'b00;
  assign unused_fwd = ^{i_src1_E, i_src2_E, i_Write_Reg_W, i_REGWrite_W, i_MEMRead_E};
`endif

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    mem_err_d  = mem_err_q;
    o_stall_F  = 1'b0;
    o_stall_D  = 1'b0;
    o_stall_E  = 1'b0;
    o_flush_D  = 1'b0;
    o_flush_E  = 1'b0;
    o_fwd1_E   = fwd1;
    o_fwd2_E   = fwd2;
    case (state_q)
      S_RUN, S_MEM_WAIT: begin
        if (i_mem_busy) begin
          o_stall_F = 1'b1;
          o_stall_D = 1'b1;
          o_stall_E = 1'b1;
          // busy_inc counts the current cycle, so the watchdog trips at the end of cycle MEM_TIMEOUT
          if (busy_inc >= 9'(MEM_TIMEOUT)) begin
            mem_err_d  = 1'b1;
            busy_cnt_d = '0;
            state_d    = S_ERR_RECOVER;
          end else begin
            busy_cnt_d = busy_inc[7:0];
            state_d    = S_MEM_WAIT;
          end
        end else begin
          busy_cnt_d = '0;
          state_d    = S_RUN;
          if (taken) begin
            o_flush_D = 1'b1;
            o_flush_E = 1'b1;
          end else if (data_hz) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_flush_E = 1'b1;
          end
        end
      end
      S_ERR_RECOVER: begin
        o_flush_D = 1'b1;
        o_flush_E = 1'b1;
        state_d   = S_RUN;
      end
      default: begin
        busy_cnt_d = '0;
        state_d    = S_RUN;
      end
    endcase
    if (rst) begin
      o_stall_F = 1'b0;
      o_stall_D = 1'b0;
      o_stall_E = 1'b0;
      o_flush_D = 1'b1;
      o_flush_E = 1'b1;
      o_fwd1_E  = 2'b00;
      o_fwd2_E  = 2'b00;
    end
  end

  assign stall_cnt_d = (o_stall_D && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      busy_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_mem_err   = mem_err_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_state     = state_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that sequences the decode/execute pipeline registers and the register-forwarding muxes. It sits beside the ID/EX register and drives its hold and bubble controls, plus the IF and IF/ID stages. It:
- detects load-use and RAW hazards, flushes on taken branches, and freezes the pipe while data memory is busy (with a watchdog);
- selects forwarding paths for the execute-stage operands and keeps a saturating stall-cycle counter.

## Interface
- REG_W, 5, register-address width
- MEM_TIMEOUT, 15, max consecutive busy cycles before watchdog error (1..255)
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_src1_D, i_src2_D  in  REG_W  decode-stage source registers
- i_use_src1_D, i_use_src2_D  in  1  decode instruction actually reads that source
- i_src1_E, i_src2_E  in  REG_W  execute-stage source registers
- i_Write_Reg_E, i_REGWrite_E, i_MEMRead_E  in  REG_W/1/1  execute-stage destination, write enable, load flag
- i_Write_Reg_M, i_REGWrite_M  in  REG_W/1  memory-stage destination, write enable
- i_Write_Reg_W, i_REGWrite_W  in  REG_W/1  writeback-stage destination, write enable
- i_Branch_E, i_Taken_E  in  1  branch in execute; resolved taken
- i_mem_busy  in  1  data memory not ready this cycle
- o_stall_F, o_stall_D, o_stall_E  out  1  hold PC, IF/ID, ID/EX
- o_flush_D, o_flush_E  out  1  zero control fields of IF/ID, ID/EX next edge
- o_fwd1_E, o_fwd2_E  out  2  operand source: 00 regfile, 01 M result, 10 W result
- o_mem_err  out  1  sticky watchdog error
- o_stall_cnt  out  CNT_W  saturating count of cycles with o_stall_D=1
- o_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR_RECOVER

## Operation
- Register 0 never produces a match.
- hitD(x) = match on a used decode source (i_use_src*_D=1).
- Load-use: i_MEMRead_E & i_REGWrite_E & hitD(i_Write_Reg_E) -> o_stall_F=o_stall_D=1, o_flush_E=1 for exactly that cycle. Resolves naturally once the load reaches M.
- Taken branch: i_Branch_E & i_Taken_E -> o_flush_D=o_flush_E=1, no stall.
  - Overrides load-use in the same cycle; the decode instruction is wrong-path.
- Forwarding, per E source: M match (REGWrite_M) -> 01; else W match (REGWrite_W) -> 10; else 00. M has priority when both match.
- FSM:
  - RUN: i_mem_busy=1 -> MEM_WAIT. In that same cycle all three stalls are 1 and no flushes occur; this overrides branch and load-use.
  - MEM_WAIT:
    - all stalls held at 1, flushes 0;
    - busy counter increments each cycle;
    - busy=0 -> RUN with counter cleared;
    - counter reaches MEM_TIMEOUT while busy=1 -> set o_mem_err, go to ERR_RECOVER.
  - ERR_RECOVER: one cycle with o_flush_D=o_flush_E=1 and stalls 0, then RUN. i_mem_busy is ignored during this cycle.
- o_mem_err stays set until rst.
- o_stall_cnt increments on every cycle with o_stall_D=1 and saturates at all-ones.

## Timing
- Stall, flush and forward outputs are combinational from the current state and inputs, valid in the same cycle.
- State, counters and o_mem_err are registered.
- Reset (rst=1 at an edge):
  - state=RUN, busy counter=0, o_stall_cnt=0, o_mem_err=0.
  - While rst is high: o_flush_D=o_flush_E=1, all stalls 0, fwd outputs 00.
- rst asserted mid-MEM_WAIT: returns to RUN on that edge, counter cleared, no error flagged.
- Memory busy for N<MEM_TIMEOUT cycles: stall asserted for exactly N cycles.
- Busy for MEM_TIMEOUT cycles: o_mem_err rises on the edge ending the MEM_TIMEOUT-th busy cycle.

## Configuration
- HAZARD_FWD_EN defined:
  - forwarding active as described;
  - only load-use stalls.
- HAZARD_FWD_EN undefined:
  - o_fwd1_E/o_fwd2_E tied 00;
  - any hitD against an E writer (REGWrite_E) or M writer (REGWrite_M) stalls F/D and flushes E until it clears;
  - W needs no stall because the register file is write-first.

## Test plan
- Load to r3 in E, decode uses r3 as src2 -> one cycle of stall_F=stall_D=flush_E=1, next cycle 0, o_stall_cnt=1.
- Taken branch in E in the same cycle as a load-use hit -> flush_D=flush_E=1, stall_D=0, o_stall_cnt unchanged.
- E src1=r5, M and W both write r5 -> fwd1_E=01; M write disabled -> 10; src1=r0 -> 00.
- i_mem_busy high 4 cycles (MEM_TIMEOUT=15) -> stall_F/D/E=1 for exactly 4 cycles, o_state back to 0, o_mem_err=0.
- i_mem_busy held high 20 cycles -> o_mem_err=1 after 15 busy cycles, one ERR_RECOVER cycle with both flushes, error stays set until rst.
- HAZARD_FWD_EN undefined, ALU writes r2 in E, decode reads r2 -> stall for 2 cycles (E then M), fwd outputs 00 throughout.
